// File: rtl/ub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ub_ctrl_pkg
//   Shared types and constants for the unified-buffer sequencer (ub_ctrl).
//   The buffer holds one 8x8 tile (64 entries). It is written one array row
//   (SIZE words) at a time, then read back one word at a time.
// -----------------------------------------------------------------------------
package ub_ctrl_pkg;

    // Systolic array dimension: words delivered per buffer write.
    localparam int SIZE   = 8;
    // Buffer entries per tile.
    localparam int DEPTH  = 64;
    // Write bursts (array rows) per tile.
    localparam int ROWS   = DEPTH / SIZE;
    // Buffer address width.
    localparam int ADDR_W = $clog2(DEPTH);
    // Row counter width.
    localparam int ROW_W  = $clog2(ROWS);
    // Low address bits covered by one row burst. The write base address is
    // the row index with these bits forced to zero.
    localparam int SIZE_W = $clog2(SIZE);

    // Last-index constants used for the phase transitions.
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(DEPTH - 1);

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : ub_ctrl_pkg

// File: rtl/ub_ctrl.sv
// -----------------------------------------------------------------------------
// ub_ctrl
//   Sequencer for the 64-entry unified buffer between the 8x8 systolic array
//   and the activation / quantised-output consumer. One start pulse runs one
//   full tile: 8 row writes of SIZE words each, followed by 64 single-word
//   reads through a valid/ready handshake, then a one-cycle done pulse.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   start       in   begin a tile; only looked at in IDLE
//   psum_valid  in   array presents SIZE partial sums this cycle
//   rd_ready    in   consumer accepts the current read word
//   ub_wr_en    out  buffer write enable (same cycle as the array data)
//   ub_wr_addr  out  buffer write base address, always a multiple of SIZE
//   ub_rd_addr  out  buffer read address (buffer read is combinational)
//   out_valid   out  the buffer word at ub_rd_addr is a valid output word
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse at tile completion
// -----------------------------------------------------------------------------
module ub_ctrl
    import ub_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              psum_valid,
    input  logic              rd_ready,
    output logic              ub_wr_en,
    output logic [ADDR_W-1:0] ub_wr_addr,
    output logic [ADDR_W-1:0] ub_rd_addr,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    state_e             state_q,   state_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0]  rd_cnt_q,  rd_cnt_d;

    // -------------------------------------------------------------------------
    // Next-state and output logic.
    // The write enable is a direct function of psum_valid in WRITE so the
    // buffer captures the array data at the same edge the counter advances.
    // The read address is likewise combinational: the buffer's read data is
    // valid in the same cycle, and the final write lands on the edge that
    // enters READ, so address 0 can be read immediately with no bubble.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement leaves one unassigned and infers a latch.
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        ub_wr_en   = 1'b0;
        ub_wr_addr = '0;
        ub_rd_addr = '0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                // psum_valid is deliberately ignored here, including when it
                // arrives together with start.
                if (start) begin
                    state_d   = WRITE;
                    row_cnt_d = '0;
                    rd_cnt_d  = '0;
                end
            end

            WRITE: begin
                ub_wr_en   = psum_valid;
                ub_wr_addr = {row_cnt_q, {SIZE_W{1'b0}}};
                // Gaps simply hold the row counter; no write occurs.
                if (psum_valid) begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    if (row_cnt_q == ROW_LAST) begin
                        state_d = READ;
                    end
                end
            end

            READ: begin
                out_valid  = 1'b1;
                ub_rd_addr = rd_cnt_q;
                // A stall (rd_ready low) holds the address for any length.
                if (rd_ready) begin
                    rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                    if (rd_cnt_q == RD_LAST) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // start is not looked at here; it is accepted next cycle.
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and counter registers. Reset aborts a tile in progress; the
    // buffer itself lives outside this block and keeps its contents.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

endmodule : ub_ctrl

// File: tb/tb_ub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ub_ctrl
//   Scoreboard bench for ub_ctrl. When a tile is launched, the driver pushes
//   the full expected transaction list of that tile: the 8 write base
//   addresses, the 64 read addresses in order and one done pulse. A separate
//   monitor, sampling on the falling edge, derives the expected outputs of
//   the current cycle from what is still outstanding in those lists and pops
//   entries as the transactions complete.
// -----------------------------------------------------------------------------
module tb_ub_ctrl;
    import ub_ctrl_pkg::*;

    localparam int CYCLE_LIMIT = 2000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              psum_valid;
    logic              rd_ready;
    logic              ub_wr_en;
    logic [ADDR_W-1:0] ub_wr_addr;
    logic [ADDR_W-1:0] ub_rd_addr;
    logic              out_valid;
    logic              busy;
    logic              done;

    ub_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .psum_valid (psum_valid),
        .rd_ready   (rd_ready),
        .ub_wr_en   (ub_wr_en),
        .ub_wr_addr (ub_wr_addr),
        .ub_rd_addr (ub_rd_addr),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Outstanding work of the tile in flight.
    int wr_q[$];
    int rd_q[$];
    int done_pending = 0;
    bit mon_en       = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    bit exp_wr, exp_ov, exp_dn, exp_busy;

    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            exp_busy = (wr_q.size() != 0) || (rd_q.size() != 0) || (done_pending != 0);
            exp_wr   = psum_valid && (wr_q.size() != 0);
            exp_ov   = (wr_q.size() == 0) && (rd_q.size() != 0);
            exp_dn   = (wr_q.size() == 0) && (rd_q.size() == 0) && (done_pending != 0);

            check("busy",      busy,      exp_busy);
            check("ub_wr_en",  ub_wr_en,  exp_wr);
            check("out_valid", out_valid, exp_ov);
            check("done",      done,      exp_dn);

            if (exp_wr) begin
                check("ub_wr_addr", ub_wr_addr, wr_q[0]);
                void'(wr_q.pop_front());
            end
            if (exp_ov) begin
                check("ub_rd_addr", ub_rd_addr, rd_q[0]);
                if (rd_ready) void'(rd_q.pop_front());
            end
            if (exp_dn) done_pending = 0;
            if (!exp_busy) begin
                check("idle_wr_addr", ub_wr_addr, 0);
                check("idle_rd_addr", ub_rd_addr, 0);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver: launch one tile from IDLE and keep driving until the model says
    // it is finished. mode 0: psum_valid always high; 1: alternating 1,0,...;
    // otherwise random. abort_at >= 0 asserts reset when that read address is
    // being presented.
    // -------------------------------------------------------------------------
    task automatic run_tile(input int mode, input int abort_at);
        int  k;
        int  stall;
        bit  forced_start;

        // start together with psum_valid: that psum must not be written.
        start      = 1'b1;
        psum_valid = 1'b1;
        rd_ready   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        for (int i = 0; i < ROWS; i++)  wr_q.push_back(i * SIZE);
        for (int i = 0; i < DEPTH; i++) rd_q.push_back(i);
        done_pending = 1;

        k            = 0;
        stall        = 0;
        forced_start = 1'b0;
        while (((wr_q.size() != 0) || (rd_q.size() != 0) || (done_pending != 0)) && k < CYCLE_LIMIT) begin
            case (mode)
                0:       psum_valid = 1'b1;
                1:       psum_valid = (k % 2 == 0);
                default: psum_valid = 1'($urandom_range(0, 1));
            endcase

            // Stray starts while busy, plus one at row 3 for certain.
            start = ($urandom_range(0, 15) == 0);
            if (!forced_start && wr_q.size() == ROWS - 3) begin
                start        = 1'b1;
                forced_start = 1'b1;
            end

            if (wr_q.size() == 0 && rd_q.size() != 0 && rd_q[0] == 10 && stall < 5) begin
                rd_ready = 1'b0;
                stall++;
            end else begin
                rd_ready = ($urandom_range(0, 3) != 0);
            end

            if (abort_at >= 0 && wr_q.size() == 0 && rd_q.size() != 0 && rd_q[0] == abort_at) begin
                rst      = 1'b1;
                rd_ready = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                wr_q.delete();
                rd_q.delete();
                done_pending = 0;
            end else begin
                @(posedge clk); #1;
            end
            k++;
        end

        start = 1'b0;
        if (k >= CYCLE_LIMIT) begin
            n_vec++;
            n_err++;
            $display("FAIL tile_timeout: tile still open after %0d cycles, expected completion", k);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        psum_valid = 1'b1;
        rd_ready   = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        // Idle with psum_valid high: no write may appear.
        repeat (3) @(posedge clk);
        #1;

        run_tile(0, -1);
        run_tile(1, -1);
        run_tile(2, -1);
        run_tile(2, 20);
        run_tile(2, -1);
        run_tile(0, -1);

        psum_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ub_ctrl
